// File: rtl/sample_gather4_8.sv
// Packs a serial valid/ready sample stream into groups of four parallel lanes.
// Short groups closed by in_last are zero-padded; a held group backpressures the input.
module sample_gather4_8 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic [WIDTH-1:0]     d,
  output logic [2:0]           out_lanes,
  output logic [CNT_WIDTH-1:0] group_count
);

  typedef enum logic [0:0] {StFill, StHeld} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [WIDTH-1:0]       slot_q [4];
  logic [WIDTH-1:0]       slot_d [4];
  logic [WIDTH-1:0]       lane_q [4];
  logic [WIDTH-1:0]       lane_d [4];
  logic [2:0]             out_lanes_q, out_lanes_d;
  logic                   out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]   group_count_q, group_count_d;
  // Keeps in_ready low until the first edge after reset release.
  logic                   run_q;

  logic accept;
  logic out_free;
  logic load;

  assign in_ready = run_q && (state_q == StFill);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_d        = slot_q;
    lane_d        = lane_q;
    out_lanes_d   = out_lanes_q;
    out_valid_d   = out_valid_q;
    group_count_d = group_count_q;
    load          = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StFill: begin
        if (accept) begin
          slot_d[idx_q] = in_data;
          if (idx_q == 2'd3 || in_last) begin
            if (out_free) begin
              load = 1'b1;
            end else begin
              // idx stays put so the held group remembers its lane count.
              state_d = StHeld;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      StHeld: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    if (load) begin
      for (int i = 0; i < 4; i++) begin
        lane_d[i] = (i <= int'(idx_q)) ? slot_d[i] : '0;
      end
      out_lanes_d   = {1'b0, idx_q} + 3'd1;
      out_valid_d   = 1'b1;
      group_count_d = group_count_q + CNT_WIDTH'(1);
      idx_d         = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFill;
      idx_q         <= 2'd0;
      out_lanes_q   <= 3'd0;
      out_valid_q   <= 1'b0;
      group_count_q <= '0;
      run_q         <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
        lane_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      out_lanes_q   <= out_lanes_d;
      out_valid_q   <= out_valid_d;
      group_count_q <= group_count_d;
      run_q         <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
        lane_q[i] <= lane_d[i];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign a           = lane_q[0];
  assign b           = lane_q[1];
  assign c           = lane_q[2];
  assign d           = lane_q[3];
  assign out_lanes   = out_lanes_q;
  assign group_count = group_count_q;

endmodule
